// File: rtl/imem_fill_ctrl_pkg.sv
// Shared definitions for the imem boot/refill sequencer: default widths,
// FSM state encoding (also used by bench monitors) and the request address helper.
package imem_fill_ctrl_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } fill_state_e;

  // Byte address of image word idx; 32-bit add wraps modulo 2**32.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_fill_timer.sv
// Per-word watchdog for the fill sequencer. Counts enabled cycles and flags
// expiry during the LIMIT-th enabled cycle; clear has priority over enable.
module imem_fill_timer #(
  parameter int LIMIT = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_expire = i_en && (cnt_q == CW'(LIMIT - 1));

  // Next count: clear, or advance while enabled and not yet expired.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_fill_ctrl.sv
// Boot/refill sequencer: copies FILL_WORDS words from main memory into imem
// words 0..FILL_WORDS-1, one outstanding request at a time, and stalls fetch
// until the image is complete.
// Optional watchdog: define IMEM_FILL_TIMEOUT_EN to abort a stuck word into ERR.
module imem_fill_ctrl
  import imem_fill_ctrl_pkg::*;
#(
  parameter int          ADDR_W         = IMEM_ADDR_W,
  parameter int          FILL_WORDS     = 1024,
  parameter logic [31:0] MEM_BASE       = 32'h0,
  parameter bit          AUTO_START     = 1'b1,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [31:0]            i_fetch_addr,
  output logic                   o_fetch_stall,
  output logic [ADDR_W-1:0]      o_imem_raddr,
  output logic                   o_imem_we,
  output logic [ADDR_W-1:0]      o_imem_waddr,
  output logic [IMEM_WORD_W-1:0] o_imem_wdata,
  output logic                   o_mm_req_valid,
  input  logic                   i_mm_req_ready,
  output logic [31:0]            o_mm_req_addr,
  input  logic                   i_mm_rsp_valid,
  input  logic [IMEM_WORD_W-1:0] i_mm_rsp_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  // idx carries one extra bit so FILL_WORDS == 2**ADDR_W compares without wrapping.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(FILL_WORDS - 1);

  fill_state_e            state_q, state_d;
  logic [ADDR_W:0]        idx_q, idx_d;
  logic [IMEM_WORD_W-1:0] wdata_q, wdata_d;
  logic                   boot_q;
  logic                   timeout;
  logic                   unused_cfg;

`ifdef IMEM_FILL_TIMEOUT_EN
  logic wd_en;

  // Watchdog runs only while a word is being fetched (REQ/WAIT).
  assign wd_en = (state_q == S_REQ) || (state_q == S_WAIT);

  imem_fill_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!wd_en),
    .i_en    (wd_en),
    .o_expire(timeout)
  );

  assign o_err      = (state_q == S_ERR);
  assign unused_cfg = ^i_fetch_addr[31:ADDR_W];
`else
  assign timeout    = 1'b0;
  assign o_err      = 1'b0;
  assign unused_cfg = ^{i_fetch_addr[31:ADDR_W], 32'(TIMEOUT_CYCLES)};
`endif

  assign o_fetch_stall = (state_q != S_DONE);
  assign o_busy        = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign o_done        = (state_q == S_DONE);
  assign o_imem_raddr  = i_fetch_addr[ADDR_W-1:0];
  assign o_imem_waddr  = idx_q[ADDR_W-1:0];
  assign o_imem_wdata  = wdata_q;
  assign o_mm_req_addr = word_byte_addr(MEM_BASE, 32'(idx_q));

  // State, index, captured word and the one-shot boot flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      boot_q  <= 1'b0;
    end
  end

  // Next-state and handshake outputs; handshakes win over a same-cycle timeout
  // so ERR is never entered with a request just accepted.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    o_mm_req_valid = 1'b0;
    o_imem_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start || (AUTO_START && boot_q)) begin
          state_d = S_REQ;
          idx_d   = '0;
        end
      end
      S_REQ: begin
        o_mm_req_valid = 1'b1;
        if (i_mm_req_ready) begin
          state_d = S_WAIT;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_WAIT: begin
        if (i_mm_rsp_valid) begin
          wdata_d = i_mm_rsp_data;
          state_d = S_WRITE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        o_imem_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_REQ;
        end
      end
      S_DONE, S_ERR: begin
        if (i_start) begin
          state_d = S_REQ;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fill_ctrl.sv
// Self-checking bench for imem_fill_ctrl: a main-memory responder issues
// responses and pushes the expected imem write into a scoreboard queue; a
// separate monitor pops and compares on every imem write strobe. Request
// addresses are checked against the image order MEM_BASE + 4*k.
// Define IMEM_FILL_TIMEOUT_EN to also exercise the watchdog.
module tb_imem_fill_ctrl;

  localparam int          AW   = 2;
  localparam int          FW   = 4;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          TMO  = 8;
`ifdef IMEM_FILL_TIMEOUT_EN
  localparam int BP_LOW  = 3;
  localparam int BP_DLY  = 3;
  localparam int RND_DLY = 1;
  localparam bit RND_RDY = 1'b0;
`else
  localparam int BP_LOW  = 6;
  localparam int BP_DLY  = 7;
  localparam int RND_DLY = 3;
  localparam bit RND_RDY = 1'b1;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk, rst_n, start;
  logic [31:0]   fetch_addr;
  logic          stall, we, req_valid, req_ready, rsp_valid, busy, done, err;
  logic [AW-1:0] raddr, waddr;
  logic [31:0]   wdata, req_addr, rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  // main-process controls
  int fill_gen = 0, ready_low_until = 0, spur_at = -1, fixed_dly = 0;
  bit rand_rdy = 0, no_rsp = 0, rand_data = 0;
  // responder-owned state
  int seen_gen = 0, req_k = 0, rsp_k = 0, accept_cnt = 0, pend_cnt = 0;
  bit pend = 0, prev_valid = 0, prev_acc = 0, acc = 0;
  logic [31:0] pend_addr, prev_addr, rd;
  wr_t wq[$];
  wr_t wexp;
  int cyc = 0;

  imem_fill_ctrl #(
    .ADDR_W(AW), .FILL_WORDS(FW), .MEM_BASE(BASE), .AUTO_START(1'b1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_fetch_addr(fetch_addr),
    .o_fetch_stall(stall), .o_imem_raddr(raddr), .o_imem_we(we), .o_imem_waddr(waddr),
    .o_imem_wdata(wdata), .o_mm_req_valid(req_valid), .i_mm_req_ready(req_ready),
    .o_mm_req_addr(req_addr), .i_mm_rsp_valid(rsp_valid), .i_mm_rsp_data(rsp_data),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Main-memory responder: drives ready/rsp, checks request order and stability.
  always @(negedge clk) begin
    if (seen_gen != fill_gen) begin
      seen_gen = fill_gen;
      req_k    = 0;
      rsp_k    = 0;
      wq.delete();
    end
    rsp_valid = 1'b0;
    if (!rst_n) begin
      pend       = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_acc) begin
        chk("req_valid_hold", 32'(req_valid), 32'd1);
        chk("req_addr_hold", req_addr, prev_addr);
      end
      if (pend && err) pend = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          rd        = pend_addr ^ 32'hA5A5_0000 ^ (rand_data ? $urandom : 32'h0);
          rsp_valid = 1'b1;
          rsp_data  = rd;
          wexp.a    = AW'(rsp_k);
          wexp.d    = rd;
          wq.push_back(wexp);
          rsp_k++;
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end else if (cyc == spur_at) begin
        rsp_valid = 1'b1;
        rsp_data  = $urandom;
      end
    end
    req_ready = (cyc >= ready_low_until) && (!rand_rdy || ($urandom_range(3) != 0));
    acc = rst_n && req_valid && req_ready;
    if (acc) begin
      chk("single_outstanding", 32'(pend), 32'd0);
      chk("req_within_image", 32'(req_k < FW), 32'd1);
      chk("req_addr", req_addr, BASE + 32'(req_k) * 32'd4);
      req_k++;
      accept_cnt++;
      pend      = 1'b1;
      pend_addr = req_addr;
      pend_cnt  = no_rsp ? 1000000 : (fixed_dly >= 0 ? fixed_dly : $urandom_range(RND_DLY));
    end
    prev_valid = rst_n && req_valid;
    prev_acc   = acc;
    prev_addr  = req_addr;
  end

  // Write monitor: every imem write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && we) begin
      chk("write_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        wr_t w;
        w = wq.pop_front();
        chk("waddr", 32'(waddr), 32'(w.a));
        chk("wdata", wdata, w.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_accepts(input int target, input int maxc);
    int n = 0;
    while (accept_cnt < target && n < maxc) begin
      tick();
      n++;
    end
    chk("accept_reached", 32'(accept_cnt >= target), 32'd1);
  endtask

  task automatic check_fill_complete(input string nm);
    chk({nm, "_req_count"}, 32'(req_k), 32'(FW));
    chk({nm, "_wq_empty"}, 32'(wq.size()), 32'd0);
    chk({nm, "_stall"}, 32'(stall), 32'd0);
  endtask

  task automatic check_fetch_passthrough();
    fetch_addr = $urandom;
    #1;
    chk("raddr", 32'(raddr), fetch_addr % (32'd1 << AW));
  endtask

  initial begin
    int base_acc;
    rst_n = 1'b0; start = 1'b0; fetch_addr = 32'h0;
    repeat (3) tick();

    // reset state
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    check_fetch_passthrough();

    // auto boot, zero-wait memory: done exactly 3*FW cycles after the start edge
    fill_gen++;
    rst_n = 1'b1;
    tick();
    repeat (3 * FW - 1) tick();
    chk("boot_done_early", 32'(done), 32'd0);
    tick();
    chk("boot_done_on_time", 32'(done), 32'd1);
    check_fill_complete("boot");
    check_fetch_passthrough();

    // spurious response in DONE
    spur_at = cyc + 1;
    repeat (3) tick();
    chk("spur_done_state", 32'(done), 32'd1);

    // restart with backpressure, spurious rsp in REQ, i_start in WAIT
    fixed_dly = BP_DLY;
    fill_gen++;
    ready_low_until = cyc + BP_LOW;
    spur_at = cyc + 2;
    base_acc = accept_cnt;
    pulse_start();
    chk("restart_stall", 32'(stall), 32'd1);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_req_valid", 32'(req_valid), 32'd1);
    wait_accepts(base_acc + 1, 50);
    pulse_start();
    wait_done(300);
    check_fill_complete("bp");

    // reset during WAIT of word 2, then the fill restarts at MEM_BASE
    fixed_dly = 4;
    fill_gen++;
    base_acc = accept_cnt;
    pulse_start();
    wait_accepts(base_acc + 3, 100);
    rst_n = 1'b0;
    tick();
    chk("midrst_stall", 32'(stall), 32'd1);
    chk("midrst_req_valid", 32'(req_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    fixed_dly = 0;
    fill_gen++;
    rst_n = 1'b1;
    wait_done(100);
    check_fill_complete("midrst");

    // randomized fills
    rand_rdy  = RND_RDY;
    fixed_dly = -1;
    rand_data = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fill_gen++;
      pulse_start();
      wait_done(400);
      check_fill_complete("rand");
      check_fetch_passthrough();
    end
    rand_rdy  = 1'b0;
    rand_data = 1'b0;
    fixed_dly = 0;

`ifdef IMEM_FILL_TIMEOUT_EN
    // watchdog: no response, ERR after TMO cycles in REQ+WAIT
    no_rsp = 1'b1;
    fill_gen++;
    pulse_start();
    repeat (TMO - 1) tick();
    chk("tmo_err_early", 32'(err), 32'd0);
    tick();
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_stall", 32'(stall), 32'd1);
    chk("tmo_req_valid", 32'(req_valid), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    no_rsp = 1'b0;
    repeat (2) tick();
    fill_gen++;
    pulse_start();
    chk("retry_err_clear", 32'(err), 32'd0);
    chk("retry_busy", 32'(busy), 32'd1);
    wait_done(100);
    check_fill_complete("retry");
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
